// File: rtl/fwrisc_mds_arbiter.sv
// Shares one mul/div/shift unit between two requesters: round-robin grant,
// one operation in flight, operand latch, result return and completion watchdog.
module fwrisc_mds_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,

  output logic [31:0] mds_in_a,
  output logic [31:0] mds_in_b,
  output logic [3:0]  mds_op,
  output logic        mds_in_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,

  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     a_lat;
  logic [31:0]     b_lat;
  logic [3:0]      op_lat;
  logic [31:0]     result;
  logic            owner;
  logic            last_grant;
  logic            timeout_q;
  logic [CNT_W-1:0] cnt;
  logic            grant;
  logic            accept;
  logic            cnt_hit;
  logic            rsp_done;

  assign cnt_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_done = owner ? rsp1_ready : rsp0_ready;

  // Ready is qualified by reset so that every output reads 0 while reset is held.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = ~req0_valid;
        req0_ready = reset && req0_valid && !grant;
        req1_ready = reset && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mds_out_valid || cnt_hit) state_next = RESP;
      end
      RESP: begin
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_lat      <= '0;
      b_lat      <= '0;
      op_lat     <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      timeout_q  <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= grant;
            a_lat  <= grant ? req1_a  : req0_a;
            b_lat  <= grant ? req1_b  : req0_b;
            op_lat <= grant ? req1_op : req0_op;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A result arriving on the expiry cycle still counts as a completion.
          if (mds_out_valid) begin
            result <= mds_out;
          end else if (cnt_hit) begin
            result    <= '0;
            timeout_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

  assign mds_in_a     = a_lat;
  assign mds_in_b     = b_lat;
  assign mds_op       = op_lat;
  assign mds_in_valid = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign timeout_err  = timeout_q;
  assign rsp0_valid   = (state == RESP) && !owner;
  assign rsp1_valid   = (state == RESP) && owner;
  assign rsp0_data    = rsp0_valid ? result : '0;
  assign rsp1_data    = rsp1_valid ? result : '0;

endmodule

// File: tb/tb_fwrisc_mds_arbiter.sv
// Scoreboard bench for fwrisc_mds_arbiter: randomized requests, a behavioural
// MDS model with chosen latencies, and a monitor comparing responses in order.
module tb_fwrisc_mds_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] mds_in_a, mds_in_b, mds_out;
  logic [3:0]  mds_op;
  logic        mds_in_valid, mds_out_valid, busy, timeout_err;

  fwrisc_mds_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .mds_in_a(mds_in_a), .mds_in_b(mds_in_b), .mds_op(mds_op), .mds_in_valid(mds_in_valid),
    .mds_out(mds_out), .mds_out_valid(mds_out_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // lat: cycles from the issue pulse to the MDS result; 0 means the MDS never answers
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; int lat; } op_t;
  typedef struct { logic owner; logic [31:0] data; int rise; logic tmo; } exp_t;
  typedef struct { int acc_cyc; int lat; } iss_t;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb_q[$];
  iss_t iss_q[$];

  int   total = 0;
  int   bad = 0;

  logic last_g = 1'b1;
  bit   inflight = 1'b0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  bit   rsp_active = 1'b0;
  exp_t cur;
  int   age = 0;
  logic err_m = 1'b0;
  bit   allow_gaps = 1'b0;
  bit   bp_mode[2] = '{1'b0, 1'b0};
  bit   spur_ok = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Operation semantics of the MDS as seen by the bench.
  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0:    return a << b[4:0];
      4'd1:    return a >> b[4:0];
      4'd2:    return $signed(a) >>> b[4:0];
      4'd3:    return a * b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic op_t randOp();
    op_t o;
    int  r;
    o.a  = $urandom;
    o.b  = $urandom;
    o.op = 4'($urandom_range(0, 4));
    r    = $urandom_range(0, 15);
    o.lat = (r == 0) ? 0 : (r == 1) ? TO + 1 : int'($urandom_range(1, TO));
    return o;
  endfunction

  task automatic presentRequests();
    if (pend0.size() > 0 && !(allow_gaps && $urandom_range(0, 4) == 0)) begin
      req0_valid = 1'b1; req0_a = pend0[0].a; req0_b = pend0[0].b; req0_op = pend0[0].op;
    end else begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
    end
    if (pend1.size() > 0 && !(allow_gaps && $urandom_range(0, 4) == 0)) begin
      req1_valid = 1'b1; req1_a = pend1[0].a; req1_b = pend1[0].b; req1_op = pend1[0].op;
    end else begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
    end
  endtask

  // One cycle: predict the grant, check readiness, record any accept, then drive.
  task automatic applyStimulus();
    int   g;
    op_t  o;
    exp_t e;
    iss_t s;
    bit   tmo;
    @(negedge clock); #1;
    if (inflight && done_cnt == acc_cnt && done_cyc < cyc) inflight = 1'b0;
    g = -1;
    if (!inflight) begin
      if (req0_valid && req1_valid) g = last_g ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    checkOutput("req_ready", {req1_ready, req0_ready}, {g == 1, g == 0});
    if (g >= 0) begin
      if (g == 0) o = pend0.pop_front();
      else        o = pend1.pop_front();
      tmo     = !(o.lat >= 1 && o.lat <= TO);
      e.owner = (g == 1);
      e.data  = tmo ? 32'h0 : refResult(o.a, o.b, o.op);
      e.rise  = cyc + 2 + (tmo ? TO : o.lat);
      e.tmo   = tmo;
      sb_q.push_back(e);
      s.acc_cyc = cyc;
      s.lat     = o.lat;
      iss_q.push_back(s);
      last_g   = (g == 1);
      inflight = 1'b1;
      acc_cnt++;
    end
    @(posedge clock); #1;
    presentRequests();
  endtask

  task automatic runOps(input int max_cycles);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || inflight || sb_q.size() > 0 || rsp_active)
           && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_within_budget", n < max_cycles, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                 mds_in_valid, busy, timeout_err}, 0);
    checkOutput({tag, "_rsp_data"}, {rsp0_data, rsp1_data}, 0);
    checkOutput({tag, "_mds_ab"}, {mds_in_a, mds_in_b}, 0);
    checkOutput({tag, "_mds_op"}, mds_op, 0);
  endtask

  // Behavioural MDS: answers each issue after its chosen latency, and injects
  // stray out_valid pulses only while the arbiter is idle or responding.
  initial begin
    bit          sched_on;
    int          sched_cyc;
    logic [31:0] sched_res;
    iss_t        s;
    sched_on = 1'b0; sched_cyc = 0; sched_res = '0;
    mds_out_valid = 1'b0;
    mds_out = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sched_on = 1'b0;
        spur_ok  = 1'b0;
        iss_q.delete();
      end else begin
        spur_ok = !busy || rsp0_valid || rsp1_valid;
        if (mds_in_valid) begin
          if (iss_q.size() == 0) begin
            checkOutput("in_valid_pending", mds_in_valid, 0);
          end else begin
            s = iss_q.pop_front();
            checkOutput("in_valid_cycle", cyc, s.acc_cyc + 1);
            if (s.lat >= 1 && s.lat <= TO + 1) begin
              sched_on  = 1'b1;
              sched_cyc = cyc + s.lat;
              sched_res = refResult(mds_in_a, mds_in_b, mds_op);
            end
          end
        end
      end
      @(posedge clock); #1;
      if (sched_on && cyc == sched_cyc) begin
        mds_out_valid = 1'b1; mds_out = sched_res; sched_on = 1'b0;
      end else if (spur_ok && $urandom_range(0, 5) == 0) begin
        mds_out_valid = 1'b1; mds_out = $urandom;
      end else begin
        mds_out_valid = 1'b0; mds_out = $urandom;
      end
    end
  end

  // Response consumers: random readiness, or a fixed 10-cycle stall in backpressure mode.
  initial begin
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      rsp0_ready = bp_mode[0] ? (age >= 10) : ($urandom_range(0, 3) != 0);
      rsp1_ready = bp_mode[1] ? (age >= 10) : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard whenever a response appears and tracks the sticky error.
  initial begin
    logic v0, v1, own;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rsp_active = 1'b0;
        err_m      = 1'b0;
        age        = 0;
        sb_q.delete();
      end else begin
        v0 = rsp0_valid;
        v1 = rsp1_valid;
        checkOutput("rsp_onehot", v0 && v1, 0);
        if (v0 || v1) begin
          own = v1;
          if (!rsp_active) begin
            if (sb_q.size() == 0) begin
              checkOutput("rsp_expected", {v1, v0}, 0);
            end else begin
              cur        = sb_q.pop_front();
              rsp_active = 1'b1;
              age        = 0;
              err_m      = err_m | cur.tmo;
              checkOutput("rsp_owner", own, cur.owner);
              checkOutput("rsp_rise_cycle", cyc, cur.rise);
            end
          end
          if (rsp_active) begin
            checkOutput("rsp_data", own ? rsp1_data : rsp0_data, cur.data);
            checkOutput("rsp_other_data", own ? rsp0_data : rsp1_data, 0);
            age++;
            if (own ? rsp1_ready : rsp0_ready) begin
              rsp_active = 1'b0;
              age        = 0;
              done_cyc   = cyc;
              done_cnt++;
            end
          end
        end else begin
          if (rsp_active) begin
            checkOutput("rsp_held", v0 || v1, 1);
            rsp_active = 1'b0;
          end
          checkOutput("rsp_idle_data", {rsp0_data, rsp1_data}, 0);
        end
        checkOutput("timeout_err", timeout_err, err_m);
      end
    end
  end

  initial begin
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    #2 reset = 1'b0;

    // Contention: both requesters valid straight out of reset.
    pend0.push_back('{a: 32'd6, b: 32'd7, op: 4'd3, lat: 3});
    pend0.push_back('{a: 32'd2, b: 32'd9, op: 4'd3, lat: 2});
    pend1.push_back('{a: 32'd3, b: 32'd5, op: 4'd3, lat: 4});
    presentRequests();
    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    reset = 1'b1;
    runOps(200);

    // Single shift operation, minimum MDS latency.
    pend0.push_back('{a: 32'h3, b: 32'h4, op: 4'd0, lat: 1});
    presentRequests();
    runOps(100);

    // Response backpressure on requester 1 while requester 0 waits.
    bp_mode[1] = 1'b1;
    pend1.push_back('{a: 32'h1234, b: 32'd3, op: 4'd0, lat: 2});
    pend0.push_back('{a: 32'd11, b: 32'd13, op: 4'd3, lat: 2});
    presentRequests();
    runOps(200);
    bp_mode[1] = 1'b0;

    // Watchdog: no answer, answer one cycle too late, answer on the expiry cycle.
    pend0.push_back('{a: 32'd5, b: 32'd5, op: 4'd3, lat: 0});
    pend0.push_back('{a: 32'd7, b: 32'd2, op: 4'd0, lat: TO + 1});
    pend0.push_back('{a: 32'd5, b: 32'd6, op: 4'd3, lat: TO});
    presentRequests();
    runOps(300);

    // Randomized traffic with gaps, random latencies and random consumers.
    allow_gaps = 1'b1;
    for (int i = 0; i < 25; i++) begin
      pend0.push_back(randOp());
      pend1.push_back(randOp());
    end
    presentRequests();
    runOps(4000);
    allow_gaps = 1'b0;

    // Reset while an operation is waiting on the MDS.
    pend0.push_back('{a: 32'd1, b: 32'd1, op: 4'd3, lat: 0});
    presentRequests();
    n = 0;
    while (!inflight && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("midop_accept_seen", inflight, 1);
    repeat (4) applyStimulus();
    #2 reset = 1'b0;
    pend0.push_back('{a: 32'd7, b: 32'd8, op: 4'd3, lat: 2});
    pend1.push_back('{a: 32'd9, b: 32'd9, op: 4'd3, lat: 2});
    presentRequests();
    #1;
    checkResetOutputs("reset_midop");
    inflight = 1'b0;
    last_g   = 1'b1;
    acc_cnt  = done_cnt;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    runOps(200);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
